// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single write port of the 32x32 integer register file between
// two writeback requesters: requester 0 is the ALU, requester 1 is the
// load/store unit. The winning write is registered onto the register-file
// write port. A 32-bit busy scoreboard lets decode stall on source operands
// whose writeback has not landed yet.
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   wb0_valid/rd/data/ready  ALU writeback handshake
//   wb1_valid/rd/data/ready  load/store writeback handshake
//   iss_valid, iss_rd        issued instruction and its destination register
//   rs1, rs2                 decode-stage source operands
//   stall                    a source operand is still busy
//   rf_we, rf_rd, rf_wdata   registered register-file write port
module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb0_valid,
  input  logic [4:0]      wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [4:0]      wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic            wb1_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int IDXW = $clog2(NREQ);

  logic [IDXW-1:0] last;
  logic            grant;
  logic [IDXW-1:0] gnt_idx;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic [31:0]     busy;
  logic [31:0]     busy_next;

  // Round-robin grant. With both requesters valid, the one that did not win
  // last time goes; a lone requester always goes. Readies are forced low
  // while reset is asserted so nothing is accepted during a flush.
  always_comb begin
    wb0_ready = 1'b0;
    wb1_ready = 1'b0;
    if (!reset) begin
      if (wb0_valid && wb1_valid) begin
        if (last == IDXW'(1)) wb0_ready = 1'b1;
        else                  wb1_ready = 1'b1;
      end else begin
        wb0_ready = wb0_valid;
        wb1_ready = wb1_valid;
      end
    end
  end

  // Mux the granted request. Readies are one-hot, so requester 1's ready
  // alone selects between the two sources.
  always_comb begin
    grant    = wb0_ready | wb1_ready;
    gnt_idx  = IDXW'(wb1_ready);
    gnt_rd   = wb1_ready ? wb1_rd   : wb0_rd;
    gnt_data = wb1_ready ? wb1_data : wb0_data;
  end

  // Scoreboard next state. The clear uses the registered write port, so a
  // register stops being busy at the same edge the register file captures
  // it. The set is applied after the clear so a newer in-flight producer of
  // the same register keeps it busy. Entry 0 never becomes busy.
  always_comb begin
    busy_next = busy;
    if (rf_we) busy_next[rf_rd] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Decode stalls while either non-zero source operand is still in flight.
  always_comb begin
    stall = (rs1 != 5'd0 && busy[rs1]) || (rs2 != 5'd0 && busy[rs2]);
  end

  // Output register, arbitration history and scoreboard. A write to x0 is
  // accepted but never enables the register file, keeping x0 at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= IDXW'(1);
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= '0;
      busy     <= 32'd0;
    end else begin
      rf_we <= grant && (gnt_rd != 5'd0);
      if (grant) begin
        last     <= gnt_idx;
        rf_rd    <= gnt_rd;
        rf_wdata <= gnt_data;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
// Directed and constrained-random stimulus for rf_wb_arbiter. A reference
// model tracks the round-robin history, the scoreboard and the registered
// write port; every expected write is queued when stimulus is driven and
// popped when the DUT presents it one cycle later.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;

  logic        m_known = 1'b0;
  logic        m_last  = 1'b1;
  logic [31:0] m_busy  = 32'd0;
  wr_t         m_out   = '0;
  logic        m_g0    = 1'b0;
  logic        m_g1    = 1'b0;

  rf_wb_arbiter #(.NREQ(2), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .stall(stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // One comparison: counted, and reported with its tag on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs against the
  // model mid-cycle, queue the expected write, then after the edge pop and
  // compare the registered write port.
  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] s1, input logic [4:0] s2);
    logic        e_r0, e_r1, e_stall;
    logic [31:0] nb;
    wr_t         nxt, got;
    reset = rst; wb0_valid = v0; wb0_rd = rd0; wb0_data = d0;
    wb1_valid = v1; wb1_rd = rd1; wb1_data = d1;
    iss_valid = iv; iss_rd = ird; rs1 = s1; rs2 = s2;
    @(negedge clk);
    e_r0 = !rst && v0 && (!v1 || m_last);
    e_r1 = !rst && v1 && (!v0 || !m_last);
    checkOutput("wb0_ready", {31'd0, wb0_ready}, {31'd0, e_r0});
    checkOutput("wb1_ready", {31'd0, wb1_ready}, {31'd0, e_r1});
    if (m_known) begin
      e_stall = (s1 != 5'd0 && m_busy[s1]) || (s2 != 5'd0 && m_busy[s2]);
      checkOutput("stall", {31'd0, stall}, {31'd0, e_stall});
    end
    nxt = m_out;
    if (rst) begin
      nxt = '0; m_busy = 32'd0; m_last = 1'b1; m_known = 1'b1;
    end else begin
      nb = m_busy;
      if (m_out.we) nb[m_out.rd] = 1'b0;
      if (iv && ird != 5'd0) nb[ird] = 1'b1;
      m_busy = nb;
      nxt.we = 1'b0;
      if (e_r0) begin nxt.we = (rd0 != 5'd0); nxt.rd = rd0; nxt.data = d0; m_last = 1'b0; end
      if (e_r1) begin nxt.we = (rd1 != 5'd0); nxt.rd = rd1; nxt.data = d1; m_last = 1'b1; end
    end
    m_g0 = e_r0; m_g1 = e_r1;
    exp_q.push_back(nxt);
    m_out = nxt;
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checkOutput("rf_we",    {31'd0, rf_we}, {31'd0, got.we});
    checkOutput("rf_rd",    {27'd0, rf_rd}, {27'd0, got.rd});
    checkOutput("rf_wdata", rf_wdata, got.data);
  endtask

  initial begin
    int          exp_rd[4];
    logic        r_v0, r_v1;
    logic [4:0]  r_rd0, r_rd1;
    logic [31:0] r_d0, r_d1;
    exp_rd = '{1, 2, 1, 2};

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_we", {31'd0, rf_we}, 32'd0);
    checkOutput("reset_rd", {27'd0, rf_rd}, 32'd0);
    checkOutput("reset_wdata", rf_wdata, 32'd0);

    $display("[TB] single ALU write");
    applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_we", {31'd0, rf_we}, 32'd1);
    checkOutput("alu_rd", {27'd0, rf_rd}, 32'd5);
    checkOutput("alu_wdata", rf_wdata, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_we_drop", {31'd0, rf_we}, 32'd0);

    $display("[TB] contention");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i, 0, 0, 0, 0);
      checkOutput("contend_rd", {27'd0, rf_rd}, exp_rd[i]);
    end

    $display("[TB] x0 write");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h1234, 0, 0, 5'd0, 5'd9);
    checkOutput("x0_we", {31'd0, rf_we}, 32'd0);
    checkOutput("x0_busy_kept", {31'd0, stall}, 32'd1);

    $display("[TB] scoreboard");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    checkOutput("sb_stall_c1", {31'd0, stall}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    applyStimulus(0, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 5'd7, 0);
    checkOutput("sb_we_c4", {31'd0, rf_we}, 32'd1);
    checkOutput("sb_stall_c4", {31'd0, stall}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    checkOutput("sb_stall_c5", {31'd0, stall}, 32'd0);

    $display("[TB] scoreboard re-issue");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    applyStimulus(0, 1, 5'd7, 32'h78, 0, 0, 0, 0, 0, 5'd7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    checkOutput("sb_reissue_stall", {31'd0, stall}, 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 0);
    applyStimulus(0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0, 0, 5'd3, 0);
    applyStimulus(1, 1, 5'd10, 32'hA1, 1, 5'd11, 32'hB1, 0, 0, 5'd3, 0);
    checkOutput("rst_mid_we", {31'd0, rf_we}, 32'd0);
    checkOutput("rst_mid_stall", {31'd0, stall}, 32'd0);
    applyStimulus(0, 1, 5'd10, 32'hA2, 1, 5'd11, 32'hB2, 0, 0, 5'd3, 0);
    checkOutput("rst_first_rd", {27'd0, rf_rd}, 32'd10);
    checkOutput("rst_first_data", rf_wdata, 32'hA2);

    $display("[TB] random traffic");
    r_v0 = 0; r_v1 = 0; r_rd0 = 0; r_rd1 = 0; r_d0 = 0; r_d1 = 0;
    m_g0 = 0; m_g1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!r_v0 || m_g0) begin
        r_v0 = 1'($urandom_range(0, 1)); r_rd0 = 5'($urandom_range(0, 31)); r_d0 = $urandom;
      end
      if (!r_v1 || m_g1) begin
        r_v1 = 1'($urandom_range(0, 1)); r_rd1 = 5'($urandom_range(0, 31)); r_d1 = $urandom;
      end
      applyStimulus(0, r_v0, r_rd0, r_d0, r_v1, r_rd1, r_d1,
                    1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32×32 integer register file. It shares the register file's single write port between two writeback requesters: requester 0 is the ALU and requester 1 is the load/store unit. It registers the winning write onto the register-file write port. It also keeps a 32-bit busy scoreboard so the decode stage can stall on operands whose writeback has not yet landed.

## Interface
- `NREQ`, default 2: number of writeback requesters. Fixed at 2; other values are not supported.
- `XLEN`, default 32: data width.
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `wb0_valid` in 1: ALU writeback request.
- `wb0_rd` in 5: ALU destination register.
- `wb0_data` in XLEN: ALU result.
- `wb0_ready` out 1: ALU request accepted this cycle.
- `wb1_valid`, `wb1_rd`, `wb1_data`, `wb1_ready`: same four signals for the load/store unit.
- `iss_valid` in 1: an instruction with a destination register is issued this cycle.
- `iss_rd` in 5: destination register of the issued instruction.
- `rs1` in 5: decode-stage source operand 1.
- `rs2` in 5: decode-stage source operand 2.
- `stall` out 1: at least one source operand is busy.
- `rf_we` out 1: registered write enable to the register file.
- `rf_rd` out 5: registered write address.
- `rf_wdata` out XLEN: registered write data.

## Operation
- Handshake:
  - A transfer happens on requester k when `wbk_valid && wbk_ready` at a rising edge.
  - A requester holds `valid`, `rd` and `data` stable until it sees `ready`.
- Arbitration is round-robin using a 1-bit `last` register (reset 1, so requester 0 wins first):
  - Only one requester valid: it is granted.
  - Both valid: the requester other than `last` is granted, and `last` updates to the granted index.
  - `last` updates only when a grant occurs.
  - The `ready` outputs are combinational from the `valid` inputs and `last`. They are one-hot or zero.
- Output register, loaded each cycle:
  - `rf_we` = grant occurred && granted rd != 0.
  - `rf_rd` and `rf_wdata` take the granted values on a grant and hold their previous values otherwise.
  - A write to x0 is still accepted (`ready` = 1) but produces `rf_we` = 0. This keeps x0 hard-wired to zero.
- Scoreboard `busy[31:0]`:
  - Set: `iss_valid && iss_rd != 0` sets `busy[iss_rd]` at the edge.
  - Clear: `rf_we` = 1 clears `busy[rf_rd]` at the edge, i.e. the same edge at which the register file captures the data.
  - Set and clear to the same index on the same edge: set wins, because a newer producer is in flight.
  - `busy[0]` is constant 0.
- `stall` is combinational: `(rs1 != 0 && busy[rs1]) || (rs2 != 0 && busy[rs2])`.
- Reset (synchronous, any cycle, including mid-transfer):
  - `wb0_ready` = `wb1_ready` = 0 while `reset` is high.
  - Next edge: `rf_we` = 0, `rf_rd` = 0, `rf_wdata` = 0, `busy` = 0, `last` = 1.
  - A request pending at reset is not written. Requesters are flushed by the same reset.

## Timing
- Grant to register-file write latency is 1 cycle. If requester k transfers at edge N, the outputs `rf_we`/`rf_rd`/`rf_wdata` are valid during cycle N+1 and the register file captures them at edge N+1.
- Read-after-writeback: the register file read is combinational, so the value is readable in cycle N+1 after edge N+1. `busy` also clears at edge N+1, so `stall` drops in the same cycle the data is readable.
- Throughput is one write per cycle.
- Under continuous contention, each requester waits at most one cycle between grants.
- Issue-to-stall latency is 1 cycle: `busy` is set at the edge after `iss_valid`.

## Test plan
- Single ALU write: `wb0_valid`=1, rd=5, data=0xDEADBEEF in cycle 0.
  - `wb0_ready`=1 in cycle 0.
  - Cycle 1: `rf_we`=1, `rf_rd`=5, `rf_wdata`=0xDEADBEEF.
  - Cycle 2: `rf_we`=0.
- Contention: both requesters valid for 4 cycles after reset, rd=1 for requester 0 and rd=2 for requester 1.
  - Grants go 0,1,0,1.
  - `rf_rd` sequence in cycles 1–4 is 1,2,1,2.
- x0 write: `wb1_valid`=1, rd=0, data=0x1234.
  - `wb1_ready`=1, `rf_we`=0 the next cycle.
  - `busy` unchanged.
- Scoreboard: issue rd=7 at cycle 0, then hold rs1=7.
  - `stall`=1 from cycle 1.
  - ALU write of rd=7 granted at cycle 3, so `rf_we`=1 in cycle 4 and `stall`=0 in cycle 5.
  - Variant: re-issue rd=7 in cycle 4. `stall` must stay 1.
- Reset mid-operation: assert `reset` for 1 cycle while both requesters are valid and busy[3]=1.
  - Both `ready`=0 during reset.
  - After reset: `rf_we`=0, `busy`=0, `stall`=0 with rs1=3.
  - First grant after reset goes to requester 0.
